// File: rtl/mul_div_if.sv
// Request/response bundle between the execute stage and the multiply/divide unit.
// The master issues operations and consumes results; the slave is the unit itself.
interface mul_div_if #(
    parameter int WIDTH = 32
);
    logic             flush;
    logic [2:0]       fn;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] r;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output flush, fn, a, b, in_valid, out_ready,
        input  in_ready, r, out_valid
    );

    modport slave (
        input  flush, fn, a, b, in_valid, out_ready,
        output in_ready, r, out_valid
    );
endinterface

// File: rtl/mul_div_unit.sv
// Radix-2 iterative RISC-V M-extension multiply/divide unit.
// Computes one product or quotient bit per cycle on unsigned magnitudes, then fixes up the sign.
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic       clk,
    input  logic       reset,
    mul_div_if.slave   bus
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state, next_state;
    logic [2:0]       fn_q;
    logic             neg_q;
    logic [WIDTH-1:0] hi_q, lo_q, op_q, r_q;
    logic [CW-1:0]    count_q;

    logic             signed_a, signed_b, a_neg, b_neg, neg_in;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic             is_special;
    logic [WIDTH-1:0] special_r;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH-1:0]   div_diff;
    logic               div_ge;
    logic [WIDTH-1:0]   hi_n, lo_n;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix, final_r;

    logic last_step;
    assign last_step = (count_q == CW'(1));

    // Operand conditioning at accept: magnitudes, result sign and the div/rem corner cases.
    always_comb begin
        signed_a   = (bus.fn == 3'd0) || (bus.fn == 3'd1) || (bus.fn == 3'd2) ||
                     (bus.fn == 3'd4) || (bus.fn == 3'd6);
        signed_b   = (bus.fn == 3'd0) || (bus.fn == 3'd1) ||
                     (bus.fn == 3'd4) || (bus.fn == 3'd6);
        a_neg      = signed_a && bus.a[WIDTH-1];
        b_neg      = signed_b && bus.b[WIDTH-1];
        a_mag      = a_neg ? -bus.a : bus.a;
        b_mag      = b_neg ? -bus.b : bus.b;
        neg_in     = (bus.fn == 3'd6) ? a_neg : (a_neg ^ b_neg);
        is_special = 1'b0;
        special_r  = '0;
        if (bus.fn[2]) begin
            if (bus.b == '0) begin
                is_special = 1'b1;
                special_r  = bus.fn[1] ? bus.a : '1;
            end else if (signed_b && (bus.a == MIN_VAL) && (bus.b == '1)) begin
                is_special = 1'b1;
                special_r  = bus.fn[1] ? '0 : MIN_VAL;
            end
        end
    end

    // One iteration: shift-add for multiply, restoring shift-subtract for divide.
    always_comb begin
        mul_sum   = {1'b0, hi_q} + ({1'b0, op_q} & {(WIDTH+1){lo_q[0]}});
        div_shift = {hi_q, lo_q[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, op_q});
        div_diff  = div_shift[WIDTH-1:0] - op_q;
        if (fn_q[2]) begin
            hi_n = div_ge ? div_diff : div_shift[WIDTH-1:0];
            lo_n = {lo_q[WIDTH-2:0], div_ge};
        end else begin
            hi_n = mul_sum[WIDTH:1];
            lo_n = {mul_sum[0], lo_q[WIDTH-1:1]};
        end
        prod     = {hi_n, lo_n};
        prod_fix = neg_q ? -prod : prod;
        quo_fix  = neg_q ? -lo_n : lo_n;
        rem_fix  = neg_q ? -hi_n : hi_n;
        case (fn_q)
            3'd0:          final_r = prod_fix[WIDTH-1:0];
            3'd1, 3'd2,
            3'd3:          final_r = prod_fix[2*WIDTH-1:WIDTH];
            3'd4, 3'd5:    final_r = quo_fix;
            default:       final_r = rem_fix;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (bus.in_valid) next_state = is_special ? DONE : BUSY;
            BUSY: if (last_step)    next_state = DONE;
            DONE: if (bus.out_ready) next_state = IDLE;
            default:                next_state = IDLE;
        endcase
        if (bus.flush) next_state = IDLE;
    end

    always_comb begin
        bus.in_ready  = (state == IDLE);
        bus.out_valid = (state == DONE);
        bus.r         = r_q;
    end

    // Datapath registers; a flush freezes them so r keeps its last value.
    always_ff @(posedge clk) begin
        if (!reset) begin
            fn_q    <= '0;
            neg_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            op_q    <= '0;
            r_q     <= '0;
            count_q <= '0;
        end else if (!bus.flush) begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    fn_q  <= bus.fn;
                    neg_q <= neg_in;
                    hi_q  <= '0;
                    lo_q  <= bus.fn[2] ? a_mag : b_mag;
                    op_q  <= bus.fn[2] ? b_mag : a_mag;
                    if (is_special) r_q <= special_r;
                    else            count_q <= CW'(WIDTH);
                end
                BUSY: begin
                    hi_q    <= hi_n;
                    lo_q    <= lo_n;
                    count_q <= count_q - CW'(1);
                    if (last_step) r_q <= final_r;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit with hand-computed expectations.
module tb_mul_div_unit;

    logic clk;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    mul_div_if #(.WIDTH(32)) bus ();

    mul_div_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issues one op and waits for out_valid; lat counts edges from the accept edge inclusive.
    task automatic run_op(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y,
                          output logic [31:0] res, output int lat);
        bus.fn = f; bus.a = x; bus.b = y; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        lat = 1;
        bus.in_valid = 1'b0; bus.a = 32'hDEADBEEF; bus.b = 32'h0; bus.fn = 3'd7;
        while (!bus.out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        res = bus.r;
    endtask

    task automatic handoff();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_in_ready got %b want 1", bus.in_ready); end
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_out_valid got %b want 0", bus.out_valid); end
        n_checks++; if (bus.r !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_r got %h want 0", bus.r); end
    endtask

    task automatic test_mul();
        logic [31:0] res; int lat;
        run_op(3'd0, 32'd7, 32'hFFFFFFFD, res, lat);
        n_checks++; if (res !== 32'hFFFFFFEB) begin n_fail++; $display("[TB] FAIL mul got %h want ffffffeb", res); end
        n_checks++; if (lat !== 33) begin n_fail++; $display("[TB] FAIL mul_latency got %0d want 33", lat); end
        handoff();
        run_op(3'd1, 32'd7, 32'hFFFFFFFD, res, lat);
        n_checks++; if (res !== 32'hFFFFFFFF) begin n_fail++; $display("[TB] FAIL mulh got %h want ffffffff", res); end
        handoff();
        run_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, res, lat);
        n_checks++; if (res !== 32'hFFFFFFFE) begin n_fail++; $display("[TB] FAIL mulhu got %h want fffffffe", res); end
        handoff();
        run_op(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, res, lat);
        n_checks++; if (res !== 32'hFFFFFFFF) begin n_fail++; $display("[TB] FAIL mulhsu got %h want ffffffff", res); end
        handoff();
    endtask

    task automatic test_div();
        logic [31:0] res; int lat;
        run_op(3'd4, 32'hFFFFFFF9, 32'd2, res, lat);
        n_checks++; if (res !== 32'hFFFFFFFD) begin n_fail++; $display("[TB] FAIL div got %h want fffffffd", res); end
        n_checks++; if (lat !== 33) begin n_fail++; $display("[TB] FAIL div_latency got %0d want 33", lat); end
        handoff();
        run_op(3'd6, 32'hFFFFFFF9, 32'd2, res, lat);
        n_checks++; if (res !== 32'hFFFFFFFF) begin n_fail++; $display("[TB] FAIL rem got %h want ffffffff", res); end
        handoff();
        run_op(3'd5, 32'd100, 32'd7, res, lat);
        n_checks++; if (res !== 32'd14) begin n_fail++; $display("[TB] FAIL divu got %h want 0000000e", res); end
        handoff();
        run_op(3'd7, 32'd100, 32'd7, res, lat);
        n_checks++; if (res !== 32'd2) begin n_fail++; $display("[TB] FAIL remu got %h want 00000002", res); end
        handoff();
    endtask

    task automatic test_special();
        logic [31:0] res; int lat;
        run_op(3'd4, 32'd5, 32'd0, res, lat);
        n_checks++; if (res !== 32'hFFFFFFFF) begin n_fail++; $display("[TB] FAIL div_by_zero got %h want ffffffff", res); end
        n_checks++; if (lat !== 1) begin n_fail++; $display("[TB] FAIL special_latency got %0d want 1", lat); end
        handoff();
        run_op(3'd6, 32'd5, 32'd0, res, lat);
        n_checks++; if (res !== 32'd5) begin n_fail++; $display("[TB] FAIL rem_by_zero got %h want 00000005", res); end
        handoff();
        run_op(3'd5, 32'd5, 32'd0, res, lat);
        n_checks++; if (res !== 32'hFFFFFFFF) begin n_fail++; $display("[TB] FAIL divu_by_zero got %h want ffffffff", res); end
        handoff();
        run_op(3'd7, 32'd5, 32'd0, res, lat);
        n_checks++; if (res !== 32'd5) begin n_fail++; $display("[TB] FAIL remu_by_zero got %h want 00000005", res); end
        handoff();
        run_op(3'd4, 32'h80000000, 32'hFFFFFFFF, res, lat);
        n_checks++; if (res !== 32'h80000000) begin n_fail++; $display("[TB] FAIL div_overflow got %h want 80000000", res); end
        n_checks++; if (lat !== 1) begin n_fail++; $display("[TB] FAIL overflow_latency got %0d want 1", lat); end
        handoff();
        run_op(3'd6, 32'h80000000, 32'hFFFFFFFF, res, lat);
        n_checks++; if (res !== 32'h0) begin n_fail++; $display("[TB] FAIL rem_overflow got %h want 00000000", res); end
        handoff();
    endtask

    task automatic test_stall();
        logic [31:0] res; int lat; int bad;
        run_op(3'd5, 32'd100, 32'd7, res, lat);
        bad = 0;
        bus.fn = 3'd0; bus.a = 32'd3; bus.b = 32'd3; bus.in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid !== 1'b1 || bus.r !== 32'd14 || bus.in_ready !== 1'b0) bad++;
        end
        bus.in_valid = 1'b0;
        n_checks++; if (bad !== 0) begin n_fail++; $display("[TB] FAIL stall_hold got %0d bad cycles want 0", bad); end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL stall_release_valid got %b want 0", bus.out_valid); end
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL stall_release_ready got %b want 1", bus.in_ready); end
    endtask

    task automatic test_flush();
        logic [31:0] res; int lat; int seen;
        bus.fn = 3'd0; bus.a = 32'd7; bus.b = 32'hFFFFFFFD; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL flush_in_ready got %b want 1", bus.in_ready); end
        n_checks++; if (bus.r !== 32'd14) begin n_fail++; $display("[TB] FAIL flush_r_kept got %h want 0000000e", bus.r); end
        bus.flush = 1'b1; bus.fn = 3'd5; bus.a = 32'd8; bus.b = 32'd2; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0; bus.in_valid = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) seen++;
            @(posedge clk); #1;
        end
        n_checks++; if (seen !== 0) begin n_fail++; $display("[TB] FAIL flush_quiet got %0d active cycles want 0", seen); end
        run_op(3'd5, 32'd9, 32'd3, res, lat);
        n_checks++; if (res !== 32'd3) begin n_fail++; $display("[TB] FAIL flush_next_op got %h want 00000003", res); end
        n_checks++; if (lat !== 33) begin n_fail++; $display("[TB] FAIL flush_next_latency got %0d want 33", lat); end
        handoff();
    endtask

    task automatic test_reset_abort();
        logic [31:0] res; int lat; int seen;
        bus.fn = 3'd4; bus.a = 32'd100; bus.b = 32'd7; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL abort_in_ready got %b want 1", bus.in_ready); end
        n_checks++; if (bus.r !== 32'h0) begin n_fail++; $display("[TB] FAIL abort_r got %h want 0", bus.r); end
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.out_valid !== 1'b0) seen++;
            @(posedge clk); #1;
        end
        n_checks++; if (seen !== 0) begin n_fail++; $display("[TB] FAIL abort_quiet got %0d valid cycles want 0", seen); end
        run_op(3'd5, 32'd9, 32'd3, res, lat);
        n_checks++; if (res !== 32'd3) begin n_fail++; $display("[TB] FAIL abort_next_op got %h want 00000003", res); end
        handoff();
    endtask

    task automatic test_back_to_back();
        logic [31:0] res; int lat;
        run_op(3'd0, 32'h00010000, 32'h00010000, res, lat);
        n_checks++; if (res !== 32'h0) begin n_fail++; $display("[TB] FAIL b2b_mul got %h want 00000000", res); end
        handoff();
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_ready got %b want 1", bus.in_ready); end
        run_op(3'd1, 32'h00010000, 32'h00010000, res, lat);
        n_checks++; if (res !== 32'h1) begin n_fail++; $display("[TB] FAIL b2b_mulh got %h want 00000001", res); end
        handoff();
        run_op(3'd0, 32'h12345678, 32'd16, res, lat);
        n_checks++; if (res !== 32'h23456780) begin n_fail++; $display("[TB] FAIL b2b_mul_shift got %h want 23456780", res); end
        handoff();
    endtask

    initial begin
        bus.flush = 1'b0; bus.fn = 3'd0; bus.a = '0; bus.b = '0;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        reset = 1'b0;
        test_reset();
        test_mul();
        test_div();
        test_special();
        test_stall();
        test_flush();
        test_reset_abort();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
